// File: rtl/button_event_queue.sv
// Turns per-button press/release pulses plus typematic auto-repeat into a
// serialized event stream: per-button pending bits, round-robin arbiter, small FIFO.
module button_event_queue #(
    parameter  int BTN_COUNT    = 8,
    parameter  int FIFO_DEPTH   = 4,
    parameter  int TICK_WIDTH   = 16,
    parameter  int REPEAT_DELAY = 24,
    parameter  int REPEAT_RATE  = 6,
    localparam int IDX_W        = $clog2(BTN_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BTN_COUNT-1:0] level,
    input  logic [BTN_COUNT-1:0] trigger,
    input  logic [BTN_COUNT-1:0] released,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [IDX_W-1:0]     evt_code,
    output logic [1:0]           evt_kind,
    output logic                 overflow,
    input  logic                 clear_overflow
);

    localparam int               PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [1:0]       KIND_PRESS   = 2'b00;
    localparam logic [1:0]       KIND_RELEASE = 2'b01;
    localparam logic [1:0]       KIND_REPEAT  = 2'b10;
    localparam logic             REPEAT_ON    = (REPEAT_DELAY != 0);

    logic [TICK_WIDTH-1:0] tick_cnt;
    logic                  tick;

    logic [BTN_COUNT-1:0]  pend_press, pend_release, pend_repeat, pend_any;
    logic [BTN_COUNT-1:0]  armed, load, rep_fire;
    logic [7:0]            rc [BTN_COUNT];
    logic [IDX_W-1:0]      rr_ptr;

    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;
    logic [1:0]            grant_kind;
    logic [BTN_COUNT-1:0]  grant_press, grant_release, grant_repeat;
    logic [BTN_COUNT-1:0]  drop_press, drop_release;

    logic [IDX_W-1:0]      fifo_code [FIFO_DEPTH];
    logic [1:0]            fifo_kind [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  fifo_full, push, pop;

    assign tick      = &tick_cnt;
    assign pend_any  = pend_press | pend_release | pend_repeat;
    assign load      = trigger & {BTN_COUNT{REPEAT_ON}};
    assign fifo_full = (count == FULL_COUNT);

    always_comb begin
        for (int i = 0; i < BTN_COUNT; i++) begin
            rep_fire[i] = armed[i] & level[i] & tick & ~load[i] & (rc[i] == 8'd1);
        end
    end

    // Walk from the far end back toward rr_ptr so the nearest pending button wins.
    always_comb begin
        int j;
        j             = 0;
        grant_valid   = 1'b0;
        grant_idx     = '0;
        grant_kind    = KIND_PRESS;
        grant_press   = '0;
        grant_release = '0;
        grant_repeat  = '0;
        if (!fifo_full) begin
            for (int k = BTN_COUNT - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= BTN_COUNT) j = j - BTN_COUNT;
                if (pend_any[j]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(j);
                end
            end
        end
        if (grant_valid) begin
            if (pend_press[grant_idx]) begin
                grant_kind             = KIND_PRESS;
                grant_press[grant_idx] = 1'b1;
            end else if (pend_release[grant_idx]) begin
                grant_kind               = KIND_RELEASE;
                grant_release[grant_idx] = 1'b1;
            end else begin
                grant_kind              = KIND_REPEAT;
                grant_repeat[grant_idx] = 1'b1;
            end
        end
    end

    // A set into a bit that is not being granted this cycle loses the event.
    assign drop_press   = trigger  & pend_press   & ~grant_press;
    assign drop_release = released & pend_release & ~grant_release;

    assign push = grant_valid;
    assign pop  = evt_valid & evt_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt     <= '0;
            pend_press   <= '0;
            pend_release <= '0;
            pend_repeat  <= '0;
            armed        <= '0;
            rr_ptr       <= '0;
            overflow     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            for (int i = 0; i < BTN_COUNT; i++) rc[i] <= 8'd0;
        end else begin
            tick_cnt     <= tick_cnt + TICK_WIDTH'(1);
            pend_press   <= (pend_press & ~grant_press) | trigger;
            pend_release <= (pend_release & ~grant_release) | released;
            pend_repeat  <= ((pend_repeat & ~grant_repeat) | rep_fire) & level;

            for (int i = 0; i < BTN_COUNT; i++) begin
                if (load[i]) begin
                    rc[i]    <= 8'(REPEAT_DELAY);
                    armed[i] <= 1'b1;
                end else if (!level[i]) begin
                    armed[i] <= 1'b0;
                end else if (armed[i] && tick) begin
                    rc[i] <= (rc[i] == 8'd1) ? 8'(REPEAT_RATE) : rc[i] - 8'd1;
                end
            end

            if (|(drop_press | drop_release)) overflow <= 1'b1;
            else if (clear_overflow)          overflow <= 1'b0;

            if (grant_valid) begin
                rr_ptr <= (grant_idx == IDX_W'(BTN_COUNT - 1)) ? '0 : grant_idx + IDX_W'(1);
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_code[wr_ptr] <= grant_idx;
            fifo_kind[wr_ptr] <= grant_kind;
        end
    end

    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? fifo_code[rd_ptr] : '0;
    assign evt_kind  = evt_valid ? fifo_kind[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: a queue-based event model checked every
// cycle, plus hand-computed event logs for each scenario.
module tb_button_event_queue;

    localparam int N      = 8;
    localparam int DEPTH  = 4;
    localparam int TW     = 2;
    localparam int DELAY  = 3;
    localparam int RATE   = 2;
    localparam int PERIOD = 1 << TW;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [N-1:0] level = '0, trigger = '0, released = '0;
    logic       evt_valid, evt_ready = 1'b0;
    logic [2:0] evt_code;
    logic [1:0] evt_kind;
    logic       overflow, clear_overflow = 1'b0;

    button_event_queue #(
        .BTN_COUNT(N), .FIFO_DEPTH(DEPTH), .TICK_WIDTH(TW),
        .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .level(level), .trigger(trigger),
        .released(released), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_kind(evt_kind), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int kind; } ev_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state
    bit  m_pp[N], m_pr[N], m_prep[N], m_armed[N];
    int  m_due[N];
    int  m_ntick = 0, m_tcnt = 0, m_rr = 0;
    bit  m_ovf = 0;
    ev_t m_q[$];

    // events accepted by the consumer, observed on the DUT
    ev_t log_q[$];
    int  log_cyc[$];
    bit  d_valid = 0;
    int  d_code = 0, d_kind = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit  tick, pop, drop, gp, gr, gq, fire;
        int  g, gk, idx;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_pp[i] = 0; m_pr[i] = 0; m_prep[i] = 0; m_armed[i] = 0; m_due[i] = 0;
            end
            m_ntick = 0; m_tcnt = 0; m_rr = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        tick = (m_tcnt % PERIOD) == PERIOD - 1;
        m_tcnt++;
        if (tick) m_ntick++;
        g = -1; gk = 0;
        if (m_q.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && (m_pp[idx] || m_pr[idx] || m_prep[idx])) g = idx;
            end
        end
        if (g >= 0) gk = m_pp[g] ? 0 : (m_pr[g] ? 1 : 2);
        pop  = (m_q.size() > 0) && evt_ready;
        drop = 0;
        for (int i = 0; i < N; i++) begin
            gp = (g == i) && (gk == 0);
            gr = (g == i) && (gk == 1);
            gq = (g == i) && (gk == 2);
            if (trigger[i] && m_pp[i] && !gp) drop = 1;
            if (released[i] && m_pr[i] && !gr) drop = 1;
            fire = 0;
            if (trigger[i] && DELAY != 0) begin
                m_armed[i] = 1;
                m_due[i]   = m_ntick + DELAY;
            end else if (!level[i]) begin
                m_armed[i] = 0;
            end else if (m_armed[i] && tick && m_ntick == m_due[i]) begin
                fire     = 1;
                m_due[i] = m_due[i] + RATE;
            end
            m_pp[i]   = (m_pp[i] && !gp) || trigger[i];
            m_pr[i]   = (m_pr[i] && !gr) || released[i];
            m_prep[i] = level[i] ? ((m_prep[i] && !gq) || fire) : 0;
        end
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back('{g, gk});
            m_rr = (g + 1) % N;
        end
        if (drop) m_ovf = 1;
        else if (clear_overflow) m_ovf = 0;
    endtask

    task automatic compare();
        chk("evt_valid", evt_valid, (m_q.size() > 0));
        chk("overflow", overflow, m_ovf);
        if (m_q.size() > 0) begin
            chk("evt_code", evt_code, m_q[0].code);
            chk("evt_kind", evt_kind, m_q[0].kind);
        end
        d_valid = evt_valid;
        d_code  = evt_code;
        d_kind  = evt_kind;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n && d_valid && evt_ready) begin
            log_q.push_back('{d_code, d_kind});
            log_cyc.push_back(cyc);
        end
        model_step();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic chk_log(int k, int code, int kind, int at);
        if (k >= log_q.size()) begin
            chk("log_missing", log_q.size(), k + 1);
        end else begin
            chk("log_code", log_q[k].code, code);
            chk("log_kind", log_q[k].kind, kind);
            if (at >= 0) chk("log_cycle", log_cyc[k], at);
        end
    endtask

    initial begin
        int t, t2, n5;

        // reset state
        @(negedge clk);
        do_reset();
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_kind", evt_kind, 0);
        chk("rst_overflow", overflow, 0);

        // single tap
        evt_ready = 1'b1;
        idle(4);
        t = cyc;
        level[3] = 1'b1; trigger[3] = 1'b1;
        step();
        trigger = '0;
        idle(5);
        t2 = cyc;
        level[3] = 1'b0; released[3] = 1'b1;
        step();
        released = '0;
        idle(6);
        chk("tap_count", log_q.size(), 2);
        chk_log(0, 3, 0, t + 2);
        chk_log(1, 3, 1, t2 + 2);

        // simultaneous presses, round-robin wrap
        do_reset();
        evt_ready = 1'b1;
        idle(2);
        t = cyc;
        trigger = 8'b1000_0101;
        step();
        trigger = '0;
        idle(6);
        t2 = cyc;
        trigger = 8'b0100_0010;
        step();
        trigger = '0;
        idle(6);
        chk("rr_count", log_q.size(), 5);
        chk_log(0, 0, 0, t + 2);
        chk_log(1, 2, 0, t + 3);
        chk_log(2, 7, 0, t + 4);
        chk_log(3, 1, 0, t2 + 2);
        chk_log(4, 6, 0, t2 + 3);

        // backpressure
        do_reset();
        evt_ready = 1'b0;
        idle(1);
        trigger = 8'b0011_1111;
        step();
        trigger = '0;
        idle(8);
        chk("bp_valid", evt_valid, 1);
        chk("bp_head", evt_code, 0);
        evt_ready = 1'b1;
        idle(10);
        chk("bp_count", log_q.size(), 6);
        for (int k = 0; k < 6; k++) chk_log(k, k, 0, -1);
        chk("bp_overflow", overflow, 0);

        // typematic repeat
        do_reset();
        evt_ready = 1'b1;
        idle(3);
        t = cyc;
        level[1] = 1'b1; trigger[1] = 1'b1;
        step();
        trigger = '0;
        idle(23);
        level[1] = 1'b0; released[1] = 1'b1;
        step();
        released = '0;
        idle(8);
        chk("rep_count", log_q.size(), 4);
        chk_log(0, 1, 0, t + 2);
        chk_log(1, 1, 2, t + 14);
        chk_log(2, 1, 2, t + 22);
        chk_log(3, 1, 1, t + 26);

        // overflow on double press while stalled
        do_reset();
        evt_ready = 1'b0;
        trigger = 8'b0000_1111;
        step();
        trigger = '0;
        idle(6);
        trigger[5] = 1'b1;
        step();
        trigger = '0;
        idle(1);
        chk("ovf_before_drop", overflow, 0);
        trigger[5] = 1'b1;
        step();
        trigger = '0;
        idle(1);
        chk("ovf_set", overflow, 1);
        trigger[5] = 1'b1; clear_overflow = 1'b1;
        step();
        trigger = '0; clear_overflow = 1'b0;
        chk("ovf_drop_wins", overflow, 1);
        evt_ready = 1'b1;
        idle(12);
        chk("ovf_count", log_q.size(), 5);
        for (int k = 0; k < 4; k++) chk_log(k, k, 0, -1);
        chk_log(4, 5, 0, -1);
        n5 = 0;
        foreach (log_q[k]) if (log_q[k].code == 5) n5++;
        chk("ovf_one_press5", n5, 1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // reset mid-stream
        do_reset();
        evt_ready = 1'b0;
        trigger = 8'b0000_0111;
        step();
        trigger = '0;
        idle(5);
        chk("mid_queued", evt_valid, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_valid", evt_valid, 0);
        chk("mid_overflow", overflow, 0);
        log_q.delete();
        log_cyc.delete();
        evt_ready = 1'b1;
        idle(10);
        chk("mid_stale", log_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
